semaforo_cruce: RTL and testbench

Parametrised two-road intersection traffic-light controller. Successor to the single-light 3-colour sequencer.
- Drives lights for road A and road B.
- Adds all-red clearance phases, a latched pedestrian request served by a dedicated walk phase, and a night mode with flashing amber.
- Sits between the board clock and the LED/relay outputs. All phase durations are set by parameters, in clk cycles.

---
 rtl/semaforo_pkg.sv | 30 +++
 rtl/semaforo_cruce_contador.sv | 18 +
 rtl/semaforo_cruce.sv | 96 +++++++++
 tb/tb_semaforo_cruce.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// semaforo_pkg: state codes, lamp-vector bit positions and phase-duration selection
package semaforo_pkg;
   typedef enum logic [2:0] {
      VERDE_A     = 3'd0,
      AMARILLO_A  = 3'd1,
      TODO_ROJO_1 = 3'd2,
      VERDE_B     = 3'd3,
      AMARILLO_B  = 3'd4,
      TODO_ROJO_2 = 3'd5,
      PEATON      = 3'd6,
      NOCHE       = 3'd7
   } estado_t;

   localparam int L_VA = 0;
   localparam int L_AA = 1;
   localparam int L_RA = 2;
   localparam int L_VB = 3;
   localparam int L_AB = 4;
   localparam int L_RB = 5;
   localparam int L_PP = 6;
   localparam int NL   = 7;

   // NOCHE returns the blink half-period, so the counter wraps there to pace the toggle
   function automatic int duracion(estado_t s, int tv, int ta, int tr, int tp, int tn);
      return (s == VERDE_A || s == VERDE_B) ? tv :
             (s == AMARILLO_A || s == AMARILLO_B) ? ta :
             (s == PEATON) ? tp :
             (s == NOCHE) ? tn : tr;
   endfunction
endpackage

// File: rtl/semaforo_cruce_contador.sv
// contador_fase: phase counter running 0..limite-1, flagging the last cycle of a phase
module contador_fase #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic [CW-1:0] limite,
   output logic          fin
);
   logic [CW-1:0] cnt;

   assign fin = cnt == limite - CW'(1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else        cnt <= (clr || fin) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/semaforo_cruce.sv
// semaforo_cruce: two-road traffic-light controller with all-red clearance,
// latched pedestrian walk phase and flashing-amber night mode
module semaforo_cruce
   import semaforo_pkg::*;
#(
   parameter int CW          = 8,
   parameter int T_VERDE     = 20,
   parameter int T_AMARILLO  = 18,
   parameter int T_TODO_ROJO = 2,
   parameter int T_PEATON    = 15,
   parameter int T_PARPADEO  = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       modo_noche,
   input  logic       boton_peaton,
   output logic       verde_a,
   output logic       amarillo_a,
   output logic       rojo_a,
   output logic       verde_b,
   output logic       amarillo_b,
   output logic       rojo_b,
   output logic       peaton_paso,
   output logic       pend_peaton,
   output logic [2:0] fase
);
   localparam int TMAX = 2 ** CW - 1;

   if (T_VERDE < 1 || T_VERDE > TMAX || T_AMARILLO < 1 || T_AMARILLO > TMAX ||
       T_TODO_ROJO < 1 || T_TODO_ROJO > TMAX || T_PEATON < 1 || T_PEATON > TMAX ||
       T_PARPADEO < 1 || T_PARPADEO > TMAX) begin : g_rango
      $error("semaforo_cruce: phase duration outside 1..2**CW-1");
   end

   estado_t st, nxt;
   logic clr, fin, parpadeo;
   logic [NL-1:0] lamps;

   contador_fase #(.CW(CW)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .limite (CW'(duracion(st, T_VERDE, T_AMARILLO, T_TODO_ROJO, T_PEATON, T_PARPADEO))),
      .fin    (fin)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st          <= TODO_ROJO_2;
         pend_peaton <= 1'b0;
         parpadeo    <= 1'b0;
      end else begin
         st          <= nxt;
         pend_peaton <= boton_peaton | (pend_peaton & !(nxt == PEATON && st != PEATON));
         parpadeo    <= (st == NOCHE) ? parpadeo ^ fin : 1'b0;
      end

   // NOCHE ignores its duration for exit; leaving restarts the counter explicitly
   always_comb begin
      nxt = st;
      clr = 1'b0;
      if (st == NOCHE) begin
         nxt = modo_noche ? NOCHE : TODO_ROJO_2;
         clr = !modo_noche;
      end else if (fin)
         case (st)
            VERDE_A:     nxt = AMARILLO_A;
            AMARILLO_A:  nxt = TODO_ROJO_1;
            TODO_ROJO_1: nxt = modo_noche ? NOCHE : VERDE_B;
            VERDE_B:     nxt = AMARILLO_B;
            AMARILLO_B:  nxt = TODO_ROJO_2;
            TODO_ROJO_2: nxt = modo_noche ? NOCHE : pend_peaton ? PEATON : VERDE_A;
            default:     nxt = VERDE_A;
         endcase
   end

   always_comb begin
      lamps       = '0;
      lamps[L_VA] = st == VERDE_A;
      lamps[L_AA] = (st == AMARILLO_A) || (st == NOCHE && parpadeo);
      lamps[L_RA] = !(st == VERDE_A || st == AMARILLO_A || st == NOCHE);
      lamps[L_VB] = st == VERDE_B;
      lamps[L_AB] = (st == AMARILLO_B) || (st == NOCHE && parpadeo);
      lamps[L_RB] = !(st == VERDE_B || st == AMARILLO_B || st == NOCHE);
      lamps[L_PP] = st == PEATON;
   end

   assign verde_a     = lamps[L_VA];
   assign amarillo_a  = lamps[L_AA];
   assign rojo_a      = lamps[L_RA];
   assign verde_b     = lamps[L_VB];
   assign amarillo_b  = lamps[L_AB];
   assign rojo_b      = lamps[L_RB];
   assign peaton_paso = lamps[L_PP];
   assign fase        = st;
endmodule

// File: tb/tb_semaforo_cruce.sv
// tb_semaforo_cruce: directed self-checking bench for the intersection controller
module tb_semaforo_cruce;
   logic clk = 1'b0, rst_n = 1'b0, modo_noche = 1'b0, boton_peaton = 1'b0;
   logic verde_a, amarillo_a, rojo_a, verde_b, amarillo_b, rojo_b, peaton_paso, pend_peaton;
   logic [2:0] fase;
   int n_cmp = 0, n_err = 0;

   semaforo_cruce dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .modo_noche   (modo_noche),
      .boton_peaton (boton_peaton),
      .verde_a      (verde_a),
      .amarillo_a   (amarillo_a),
      .rojo_a       (rojo_a),
      .verde_b      (verde_b),
      .amarillo_b   (amarillo_b),
      .rojo_b       (rojo_b),
      .peaton_paso  (peaton_paso),
      .pend_peaton  (pend_peaton),
      .fase         (fase)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // called on the first sampling point of a phase; returns on the first sample of the next one
   task automatic fase_dura(input string tag, input logic [2:0] st, input int len);
      int n = 0;
      check({tag, "_fase"}, fase, st);
      while (fase == st && n < 300) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_len"}, n, len);
   endtask

   always @(negedge clk)
      if (fase != 3'd7) begin
         check("seguridad", !rojo_a && !rojo_b, 0);
         check("unico_a", verde_a + amarillo_a + rojo_a, 1);
         check("unico_b", verde_b + amarillo_b + rojo_b, 1);
      end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_rojo", {rojo_a, rojo_b, verde_a, amarillo_a, verde_b, amarillo_b, peaton_paso}, 7'b1100000);
      check("rst_fase", fase, 5);
      check("rst_pend", pend_peaton, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst1", fase, 5);
      @(negedge clk);
      check("post_rst2", fase, 0);
      check("post_rst_va", verde_a, 1);

      fase_dura("c_va", 0, 20);
      fase_dura("c_aa", 1, 18);
      fase_dura("c_tr1", 2, 2);
      fase_dura("c_vb", 3, 20);
      fase_dura("c_ab", 4, 18);
      fase_dura("c_tr2", 5, 2);

      fase_dura("p_va", 0, 20);
      fase_dura("p_aa", 1, 18);
      fase_dura("p_tr1", 2, 2);
      boton_peaton = 1'b1;
      @(negedge clk);
      boton_peaton = 1'b0;
      check("p_pend_set", pend_peaton, 1);
      fase_dura("p_vb", 3, 19);
      fase_dura("p_ab", 4, 18);
      fase_dura("p_tr2", 5, 2);
      check("p_paso", peaton_paso, 1);
      check("p_pend_clr", pend_peaton, 0);
      fase_dura("p_peaton", 6, 15);
      check("p_vuelta", fase, 0);

      boton_peaton = 1'b1;
      @(negedge clk);
      boton_peaton = 1'b0;
      check("s_pend", pend_peaton, 1);
      fase_dura("s_va", 0, 19);
      fase_dura("s_aa", 1, 18);
      fase_dura("s_tr1", 2, 2);
      fase_dura("s_vb", 3, 20);
      fase_dura("s_ab", 4, 18);
      check("s_tr2", fase, 5);
      @(negedge clk);
      boton_peaton = 1'b1;
      @(negedge clk);
      boton_peaton = 1'b0;
      check("s_entra", fase, 6);
      check("s_pend_keep", pend_peaton, 1);
      fase_dura("s_peaton1", 6, 15);
      fase_dura("s2_va", 0, 20);
      fase_dura("s2_aa", 1, 18);
      fase_dura("s2_tr1", 2, 2);
      fase_dura("s2_vb", 3, 20);
      fase_dura("s2_ab", 4, 18);
      fase_dura("s2_tr2", 5, 2);
      check("s2_pend_clr", pend_peaton, 0);
      fase_dura("s_peaton2", 6, 15);

      modo_noche = 1'b1;
      fase_dura("n_va", 0, 20);
      fase_dura("n_aa", 1, 18);
      fase_dura("n_tr1", 2, 2);
      check("n_fase", fase, 7);
      for (int i = 0; i < 15; i++) begin
         check("n_amb_a", amarillo_a, (i / 5) % 2);
         check("n_amb_b", amarillo_b, (i / 5) % 2);
         check("n_resto", {rojo_a, rojo_b, verde_a, verde_b, peaton_paso}, 0);
         boton_peaton = (i == 7);
         @(negedge clk);
      end
      boton_peaton = 1'b0;
      check("n_pend", pend_peaton, 1);
      check("n_sigue", fase, 7);
      modo_noche = 1'b0;
      @(negedge clk);
      fase_dura("n_tr2", 5, 2);
      fase_dura("n_peaton", 6, 15);

      fase_dura("r_va", 0, 20);
      fase_dura("r_aa", 1, 18);
      fase_dura("r_tr1", 2, 2);
      fase_dura("r_vb", 3, 20);
      boton_peaton = 1'b1;
      @(negedge clk);
      boton_peaton = 1'b0;
      check("r_pend", pend_peaton, 1);
      check("r_ab", fase, 4);
      #2 rst_n = 1'b0;
      #1;
      check("r_lamps", {rojo_a, rojo_b, verde_a, amarillo_a, verde_b, amarillo_b, peaton_paso}, 7'b1100000);
      check("r_fase", fase, 5);
      check("r_pend_clr", pend_peaton, 0);
      @(negedge clk);
      rst_n = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
